// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl
// Miss handler sitting between the data cache and the backing data memory.
// A miss request optionally writes the dirty victim line back word-by-word,
// then reads the missing line word-by-word into a line buffer. The full line
// is returned to the cache in a single one-cycle response beat.
//
// Build option: define DCRC_CWF_EN for critical-word-first fill ordering.
// The fill then starts at req_word and wraps around the line, and crit_valid
// pulses with the first returned word. Without DCRC_CWF_EN the fill runs
// 0..WORDS_PER_LINE-1, req_word is ignored, and crit_valid/crit_data are 0.
//
// Handshakes:
//   request : accepted on a cycle where req_valid & req_ready; req_ready is
//             high only while idle, so the requester holds its request (and
//             all request fields) until then. req_valid while busy is ignored.
//   memory  : mem_req/mem_we/mem_line/mem_word/mem_wdata describe the current
//             word access and stay stable until a cycle with mem_ack; the
//             address advances the cycle after each ack. mem_ack while
//             mem_req is low has no effect.
//   response: resp_valid is a one-cycle pulse; there is no back-pressure.

module dcache_refill_ctrl #(
    parameter int  XLEN           = 32,
    parameter int  WORDS_PER_LINE = 4,
    parameter int  LINE_ADDR_BITS = 4,
    localparam int WORD_BITS      = $clog2(WORDS_PER_LINE),
    localparam int LINE_W         = XLEN * WORDS_PER_LINE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wb,
    input  logic [LINE_ADDR_BITS-1:0] req_wb_line,
    input  logic [LINE_W-1:0]         req_wb_data,
    input  logic [LINE_ADDR_BITS-1:0] req_fill_line,
    input  logic [WORD_BITS-1:0]      req_word,
    output logic                      resp_valid,
    output logic [LINE_W-1:0]         resp_data,
    output logic                      crit_valid,
    output logic [XLEN-1:0]           crit_data,
    output logic                      busy,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [LINE_ADDR_BITS-1:0] mem_line,
    output logic [WORD_BITS-1:0]      mem_word,
    output logic [XLEN-1:0]           mem_wdata,
    input  logic                      mem_ack,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [WORD_BITS-1:0] CNT_LAST = WORD_BITS'(WORDS_PER_LINE - 1);

    state_e                      state_q, state_d;
    logic [WORD_BITS-1:0]        cnt_q, cnt_d;
    logic [LINE_ADDR_BITS-1:0]   wb_line_q, wb_line_d;
    logic [LINE_W-1:0]           wb_data_q, wb_data_d;
    logic [LINE_ADDR_BITS-1:0]   fill_line_q, fill_line_d;
    logic [LINE_W-1:0]           buf_q, buf_d;

    // Word index the fill starts at (and must wrap back to in order to end),
    // as seen from the live request and from the captured request.
    logic [WORD_BITS-1:0]        start_req;
    logic [WORD_BITS-1:0]        start_cap;
    logic [WORD_BITS-1:0]        cnt_inc;

    assign cnt_inc = cnt_q + WORD_BITS'(1);

`ifdef DCRC_CWF_EN
    logic [WORD_BITS-1:0]        word_q, word_d;

    assign start_req = req_word;
    assign start_cap = word_q;
`else
    logic                        unused_word;

    assign start_req   = '0;
    assign start_cap   = '0;
    assign unused_word = ^req_word;
`endif

    // State, counter, captured request and line buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wb_line_q   <= '0;
            wb_data_q   <= '0;
            fill_line_q <= '0;
            buf_q       <= '0;
`ifdef DCRC_CWF_EN
            word_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_line_q   <= wb_line_d;
            wb_data_q   <= wb_data_d;
            fill_line_q <= fill_line_d;
            buf_q       <= buf_d;
`ifdef DCRC_CWF_EN
            word_q      <= word_q_next();
`endif
        end
    end

`ifdef DCRC_CWF_EN
    function automatic logic [WORD_BITS-1:0] word_q_next();
        return word_d;
    endfunction
`endif

    // Next-state logic: request capture, word counting and fill buffering.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_line_d   = wb_line_q;
        wb_data_d   = wb_data_q;
        fill_line_d = fill_line_q;
        buf_d       = buf_q;
        req_ready   = 1'b0;
`ifdef DCRC_CWF_EN
        word_d      = word_q;
`endif

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wb_line_d   = req_wb_line;
                    wb_data_d   = req_wb_data;
                    fill_line_d = req_fill_line;
`ifdef DCRC_CWF_EN
                    word_d      = req_word;
`endif
                    if (req_wb) begin
                        state_d = S_WB;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_FILL;
                        cnt_d   = start_req;
                    end
                end
            end

            S_WB: begin
                if (mem_ack) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FILL;
                        cnt_d   = start_cap;
                    end
                end
            end

            S_FILL: begin
                if (mem_ack) begin
                    buf_d[cnt_q*XLEN +: XLEN] = mem_rdata;
                    cnt_d                     = cnt_inc;
                    // Every word has been read once the counter wraps back
                    // to the word the fill started from.
                    if (cnt_inc == start_cap) begin
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Memory port, response and status outputs decoded from the registers.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_line  = '0;
        mem_word  = '0;
        mem_wdata = '0;

        case (state_q)
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_line  = wb_line_q;
                mem_word  = cnt_q;
                mem_wdata = wb_data_q[cnt_q*XLEN +: XLEN];
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_line = fill_line_q;
                mem_word = cnt_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Critical word: each word index is read exactly once per fill, so the
    // ack on the start index is the first fill ack.
    always_comb begin
        crit_valid = 1'b0;
        crit_data  = '0;
`ifdef DCRC_CWF_EN
        if (state_q == S_FILL && mem_ack && cnt_q == word_q) begin
            crit_valid = 1'b1;
            crit_data  = mem_rdata;
        end
`endif
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = buf_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb_dcache_refill_ctrl
// Bench for dcache_refill_ctrl: a behavioural word memory answers the DUT's
// memory port, a reference model derives the expected memory traffic and
// returned line from the miss rules, and a table plus random requests drive it.

module tb_dcache_refill_ctrl;

    localparam int XLEN   = 32;
    localparam int WPL    = 4;
    localparam int LAB    = 4;
    localparam int LINE_W = XLEN * WPL;
    localparam int OP_W   = 1 + LAB + 2 + XLEN;

`ifdef DCRC_CWF_EN
    localparam bit CWF_B = 1'b1;
`else
    localparam bit CWF_B = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic              req_valid;
    logic              req_ready;
    logic              req_wb;
    logic [LAB-1:0]    req_wb_line;
    logic [LINE_W-1:0] req_wb_data;
    logic [LAB-1:0]    req_fill_line;
    logic [1:0]        req_word;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_data;
    logic              crit_valid;
    logic [XLEN-1:0]   crit_data;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [LAB-1:0]    mem_line;
    logic [1:0]        mem_word;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic [1:0]        dbg_state;

    dcache_refill_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wb        (req_wb),
        .req_wb_line   (req_wb_line),
        .req_wb_data   (req_wb_data),
        .req_fill_line (req_fill_line),
        .req_word      (req_word),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .crit_valid    (crit_valid),
        .crit_data     (crit_data),
        .busy          (busy),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_line      (mem_line),
        .mem_word      (mem_word),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [OP_W-1:0] exp_q[$];
    logic [OP_W-1:0] obs_q[$];

    logic [XLEN-1:0] mem_arr[64];   // memory seen by the DUT
    logic [XLEN-1:0] ref_mem[64];   // reference model's memory image

    bit              ack_rand = 1'b0;
    int              ack_gap  = 0;
    int              wait_cnt = 0;
    int              crit_cnt = 0;
    logic [XLEN-1:0] crit_seen = '0;
    bit              crit_nz   = 1'b0;

    function automatic logic [OP_W-1:0] mk_op(input logic we, input logic [LAB-1:0] l,
                                              input logic [1:0] w, input logic [XLEN-1:0] d);
        return {we, l, w, d};
    endfunction

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Decides mem_ack mid-cycle, serves reads from mem_arr, commits writes and
    // logs every acknowledged access; then samples the critical-word outputs.
    always begin
        logic       a;
        logic [5:0] idx;
        @(negedge clk);
        if (mem_req) begin
            a        = ack_rand ? ($urandom_range(0, 2) == 0) : (wait_cnt >= ack_gap);
            wait_cnt = a ? 0 : wait_cnt + 1;
        end else begin
            a        = ack_rand && ($urandom_range(0, 3) == 0);
            wait_cnt = 0;
        end
        mem_ack = a;
        idx     = {mem_line, mem_word};
        if (mem_req && a) begin
            if (mem_we) begin
                mem_arr[idx] = mem_wdata;
                mem_rdata    = $urandom;
                obs_q.push_back(mk_op(1'b1, mem_line, mem_word, mem_wdata));
            end else begin
                mem_rdata = mem_arr[idx];
                obs_q.push_back(mk_op(1'b0, mem_line, mem_word, mem_arr[idx]));
            end
        end else begin
            mem_rdata = $urandom;
        end
        #1;
        if (crit_valid) begin
            crit_cnt++;
            crit_seen = crit_data;
        end
        if (!CWF_B && crit_data != '0) crit_nz = 1'b1;
    end

    // ---------------- reference model ----------------
    // Writeback of all words in order, then reads of the missing line in the
    // fill order; the returned line is the memory image after the writeback.
    task automatic model_req(input logic wb, input logic [LAB-1:0] wbl, input logic [LINE_W-1:0] wbd,
                             input logic [LAB-1:0] fl, input logic [1:0] wd,
                             output logic [LINE_W-1:0] mresp, output int ccnt, output logic [XLEN-1:0] cdata);
        int start;
        int w;
        if (wb) begin
            for (int k = 0; k < WPL; k++) begin
                exp_q.push_back(mk_op(1'b1, wbl, 2'(k), wbd[k*XLEN +: XLEN]));
                ref_mem[int'(wbl)*WPL + k] = wbd[k*XLEN +: XLEN];
            end
        end
        start = CWF_B ? int'(wd) : 0;
        for (int k = 0; k < WPL; k++) begin
            w = (start + k) % WPL;
            exp_q.push_back(mk_op(1'b0, fl, 2'(w), ref_mem[int'(fl)*WPL + w]));
        end
        for (int k = 0; k < WPL; k++) mresp[k*XLEN +: XLEN] = ref_mem[int'(fl)*WPL + k];
        ccnt  = CWF_B ? 1 : 0;
        cdata = CWF_B ? ref_mem[int'(fl)*WPL + int'(wd)] : '0;
    endtask

    // ---------------- driver ----------------
    // Entered #1 after a rising edge with the DUT idle. Cycle 0 is the cycle
    // the request is accepted in; lat is the cycle resp_valid is seen in.
    task automatic run_req(input logic wb, input logic [LAB-1:0] wbl, input logic [LINE_W-1:0] wbd,
                           input logic [LAB-1:0] fl, input logic [1:0] wd, input bit junk,
                           output int lat, output logic [LINE_W-1:0] rd,
                           output bit busy_ok, output bit post_ok);
        int waitc;
        req_valid     = 1'b1;
        req_wb        = wb;
        req_wb_line   = wbl;
        req_wb_data   = wbd;
        req_fill_line = fl;
        req_word      = wd;
        waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        @(posedge clk); #1;
        // Scramble the request fields; with junk set, keep a bogus request
        // pending while the controller is busy.
        req_valid     = junk;
        req_wb        = 1'($urandom);
        req_wb_line   = 4'($urandom);
        req_wb_data   = {$urandom, $urandom, $urandom, $urandom};
        req_fill_line = 4'($urandom);
        req_word      = 2'($urandom);
        lat     = -1;
        rd      = '0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            if (resp_valid) begin
                lat = c;
                rd  = resp_data;
                break;
            end
            if (!busy || req_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        post_ok = !resp_valid && !busy && req_ready;
    endtask

    task automatic do_and_check(input string tag, input logic wb, input logic [LAB-1:0] wbl,
                                input logic [LINE_W-1:0] wbd, input logic [LAB-1:0] fl,
                                input logic [1:0] wd, input bit junk, input int exp_lat,
                                input bit use_const, input logic [LINE_W-1:0] const_resp);
        logic [LINE_W-1:0] mresp;
        logic [LINE_W-1:0] rd;
        logic [XLEN-1:0]   cdata;
        int                ccnt;
        int                lat;
        int                n;
        bit                bok;
        bit                pok;
        exp_q.delete();
        obs_q.delete();
        crit_cnt  = 0;
        crit_seen = '0;
        model_req(wb, wbl, wbd, fl, wd, mresp, ccnt, cdata);
        run_req(wb, wbl, wbd, fl, wd, junk, lat, rd, bok, pok);
        check($sformatf("%s resp_seen", tag), LINE_W'(lat > 0), LINE_W'(1));
        if (exp_lat >= 0) check($sformatf("%s latency", tag), LINE_W'(lat), LINE_W'(exp_lat));
        check($sformatf("%s resp_data", tag), rd, mresp);
        if (use_const) check($sformatf("%s resp_const", tag), rd, const_resp);
        check($sformatf("%s busy_hold", tag), LINE_W'(bok), LINE_W'(1));
        check($sformatf("%s idle_after", tag), LINE_W'(pok), LINE_W'(1));
        check($sformatf("%s crit_count", tag), LINE_W'(crit_cnt), LINE_W'(ccnt));
        check($sformatf("%s crit_data", tag), LINE_W'(crit_seen), LINE_W'(cdata));
        check($sformatf("%s op_count", tag), LINE_W'(obs_q.size()), LINE_W'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s op%0d", tag, i), LINE_W'(obs_q[i]), LINE_W'(exp_q[i]));
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic              wb;
        logic [LAB-1:0]    wb_line;
        logic [LINE_W-1:0] wb_data;
        logic [LAB-1:0]    fill_line;
        logic [1:0]        word;
        int                gap;       // idle cycles before each ack
        bit                junk;      // hold a bogus request while busy
        int                exp_lat;
        logic [LINE_W-1:0] exp_resp;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin
        bit saw_resp;

        rst           = 1'b0;
        req_valid     = 1'b0;
        req_wb        = 1'b0;
        req_wb_line   = '0;
        req_wb_data   = '0;
        req_fill_line = '0;
        req_word      = '0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 32'((i / WPL) * 16 + (i % WPL));
            ref_mem[i] = mem_arr[i];
        end

        // Memory word (line l, word w) initially holds l*16 + w.
        vecs[0] = '{1'b0, 4'd0, 128'd0, 4'd3, 2'd0, 0, 1'b0, 5,
                    128'h00000033_00000032_00000031_00000030};
        vecs[1] = '{1'b1, 4'd5, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, 4'd9, 2'd0, 0, 1'b0, 9,
                    128'h00000093_00000092_00000091_00000090};
        vecs[2] = '{1'b1, 4'd7, 128'h00000004_00000003_00000002_00000001, 4'd7, 2'd1, 0, 1'b0, 9,
                    128'h00000004_00000003_00000002_00000001};
        vecs[3] = '{1'b0, 4'd0, 128'd0, 4'd2, 2'd3, 2, 1'b1, 13,
                    128'h00000023_00000022_00000021_00000020};
        vecs[4] = '{1'b1, 4'd11, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 4'd12, 2'd1, 1, 1'b1, 17,
                    128'h000000C3_000000C2_000000C1_000000C0};
        vecs[5] = '{1'b0, 4'd0, 128'd0, 4'd4, 2'd2, 0, 1'b0, 5,
                    128'h00000043_00000042_00000041_00000040};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", LINE_W'(busy), LINE_W'(0));
        check("reset req_ready", LINE_W'(req_ready), LINE_W'(1));
        check("reset mem_req", LINE_W'(mem_req), LINE_W'(0));
        check("reset resp_valid", LINE_W'(resp_valid), LINE_W'(0));
        check("reset crit_valid", LINE_W'(crit_valid), LINE_W'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        ack_rand = 1'b0;
        foreach (vecs[i]) begin
            ack_gap = vecs[i].gap;
            do_and_check($sformatf("vec%0d", i), vecs[i].wb, vecs[i].wb_line, vecs[i].wb_data,
                         vecs[i].fill_line, vecs[i].word, vecs[i].junk, vecs[i].exp_lat,
                         1'b1, vecs[i].exp_resp);
        end

        // Reset in the middle of a fill, after two words have been read.
        ack_gap = 0;
        obs_q.delete();
        req_valid     = 1'b1;
        req_wb        = 1'b0;
        req_fill_line = 4'd6;
        req_word      = 2'd0;
        @(posedge clk); #1;          // accepted; cycle 1
        req_valid = 1'b0;
        @(posedge clk); #1;          // cycle 2
        @(posedge clk); #1;          // cycle 3, two fill acks done
        check("midfill acks_before_reset", LINE_W'(obs_q.size()), LINE_W'(2));
        check("midfill busy_before_reset", LINE_W'(busy), LINE_W'(1));
        rst = 1'b0;
        @(posedge clk); #1;
        check("midfill busy", LINE_W'(busy), LINE_W'(0));
        check("midfill mem_req", LINE_W'(mem_req), LINE_W'(0));
        check("midfill req_ready", LINE_W'(req_ready), LINE_W'(1));
        check("midfill resp_valid", LINE_W'(resp_valid), LINE_W'(0));
        check("midfill resp_data_cleared", resp_data, '0);
        rst = 1'b1;
        saw_resp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (resp_valid || mem_req) saw_resp = 1'b1;
        end
        check("midfill no_resume", LINE_W'(saw_resp), LINE_W'(0));
        check("midfill acks_total", LINE_W'(obs_q.size()), LINE_W'(2));
        obs_q.delete();

        // Random requests against the reference model with random ack timing.
        ack_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_and_check($sformatf("rnd%0d", i), 1'($urandom), 4'($urandom),
                         {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
                         2'($urandom_range(0, 3)), 1'($urandom), -1, 1'b0, '0);
        end
        ack_rand = 1'b0;

        check("crit_data idle zero", LINE_W'(crit_nz), LINE_W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
